// File: rtl/uart_pkg.sv
// Shared definitions for the memory-mapped UART: register offsets, CON bit
// positions and the TX/RX state encodings.
package uart_pkg;

    localparam logic [31:0] OFS_TXD = 32'd0;
    localparam logic [31:0] OFS_RXD = 32'd4;
    localparam logic [31:0] OFS_CON = 32'd8;

    localparam int CON_TX_IRQ_EN  = 0;
    localparam int CON_RX_IRQ_EN  = 1;
    localparam int CON_TX_DONE    = 2;
    localparam int CON_RX_READY   = 3;
    localparam int CON_TX_BUSY    = 4;
    localparam int CON_FRAME_ERR  = 5;
    localparam int CON_OVERRUN    = 6;

    typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;
    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

endpackage

// File: rtl/uart_baud_counter.sv
// Bit-period timer: counts 0..CLKS_PER_BIT-1 while enabled and flags the
// half-bit and full-bit points of the current period.
module uart_baud_counter #(
    parameter int CLKS_PER_BIT = 10417
) (
    input  logic clk,
    input  logic reset,
    input  logic enable,
    input  logic clear,
    output logic half_tick,
    output logic full_tick
);
    localparam int W = $clog2(CLKS_PER_BIT);
    localparam logic [W-1:0] LAST = W'(CLKS_PER_BIT - 1);
    localparam logic [W-1:0] HALF = W'(CLKS_PER_BIT / 2 - 1);

    logic [W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            cnt <= '0;
        end else if (enable) begin
            cnt <= (cnt == LAST) ? '0 : cnt + W'(1);
        end
    end

    assign half_tick = enable && (cnt == HALF);
    assign full_tick = enable && (cnt == LAST);

endmodule

// File: rtl/uart_bus_slave.sv
// 8N1 UART target on the CPU data bus: TXD/RXD/CON registers, combinational
// read data, clear-on-read status flags and a level interrupt.
//
//   state    | meaning
//   TX_IDLE  | line high, waiting for a TXD write
//   TX_START | driving the start bit (0)
//   TX_DATA  | driving data bits LSB first
//   TX_STOP  | driving the stop bit (1), sets tx_done at the end
//   RX_IDLE  | waiting for a synchronized falling edge
//   RX_START | confirming the start bit at mid-bit
//   RX_DATA  | sampling 8 data bits at mid-bit
//   RX_STOP  | sampling the stop bit, then back to idle
module uart_bus_slave
    import uart_pkg::*;
#(
    parameter int          CLKS_PER_BIT = 10417,
    parameter logic [31:0] BASE_ADDR    = 32'h40000018
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        MemRead,
    input  logic        MemWrite,
    input  logic [31:0] Address,
    input  logic [31:0] Write_data,
    output logic [31:0] Read_data,
    input  logic        uart_rx,
    output logic        uart_tx,
    output logic        irqout
);
    tx_state_t   tx_state;
    rx_state_t   rx_state;
    logic [7:0]  tx_byte, rx_shift, rx_data;
    logic [2:0]  tx_bit_idx, rx_bit_idx;
    logic        tx_full, rx_half, rx_full, unused_tx_half;
    logic        rx_meta, rx_sync, rx_prev;
    logic        tx_done, rx_ready, frame_err, overrun, tx_irq_en, rx_irq_en;
    logic        unused_wdata;

    logic sel_txd, sel_rxd, sel_con, wr_txd, wr_con, rd_rxd, rd_con;
    logic tx_busy, tx_done_set, rx_stop_tick, rx_ok, rx_bad;

    assign sel_txd = (Address == BASE_ADDR + OFS_TXD);
    assign sel_rxd = (Address == BASE_ADDR + OFS_RXD);
    assign sel_con = (Address == BASE_ADDR + OFS_CON);
    assign wr_txd  = MemWrite && sel_txd;
    assign wr_con  = MemWrite && sel_con;
    assign rd_rxd  = MemRead && sel_rxd;
    assign rd_con  = MemRead && sel_con;
    assign unused_wdata = ^Write_data[31:8];

    assign tx_busy      = (tx_state != TX_IDLE);
    assign tx_done_set  = (tx_state == TX_STOP) && tx_full;
    assign rx_stop_tick = (rx_state == RX_STOP) && rx_full;
    assign rx_ok        = rx_stop_tick && rx_sync;
    assign rx_bad       = rx_stop_tick && !rx_sync;

    uart_baud_counter #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_tx_baud (
        .clk(clk), .reset(reset),
        .enable(tx_state != TX_IDLE), .clear(tx_state == TX_IDLE),
        .half_tick(unused_tx_half), .full_tick(tx_full)
    );

    // Restarting at the start-bit midpoint makes every later full tick land mid-bit.
    uart_baud_counter #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx_baud (
        .clk(clk), .reset(reset),
        .enable(rx_state != RX_IDLE),
        .clear((rx_state == RX_IDLE) || ((rx_state == RX_START) && rx_half)),
        .half_tick(rx_half), .full_tick(rx_full)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            tx_state   <= TX_IDLE;
            uart_tx    <= 1'b1;
            tx_byte    <= '0;
            tx_bit_idx <= '0;
        end else begin
            case (tx_state)
                TX_IDLE: if (wr_txd) begin
                    tx_byte  <= Write_data[7:0];
                    uart_tx  <= 1'b0;
                    tx_state <= TX_START;
                end
                TX_START: if (tx_full) begin
                    uart_tx    <= tx_byte[0];
                    tx_bit_idx <= '0;
                    tx_state   <= TX_DATA;
                end
                TX_DATA: if (tx_full) begin
                    if (tx_bit_idx == 3'd7) begin
                        uart_tx  <= 1'b1;
                        tx_state <= TX_STOP;
                    end else begin
                        uart_tx    <= tx_byte[tx_bit_idx + 3'd1];
                        tx_bit_idx <= tx_bit_idx + 3'd1;
                    end
                end
                TX_STOP: if (tx_full) tx_state <= TX_IDLE;
                default: tx_state <= TX_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rx_meta    <= 1'b1;
            rx_sync    <= 1'b1;
            rx_prev    <= 1'b1;
            rx_state   <= RX_IDLE;
            rx_shift   <= '0;
            rx_bit_idx <= '0;
        end else begin
            rx_meta <= uart_rx;
            rx_sync <= rx_meta;
            rx_prev <= rx_sync;
            case (rx_state)
                RX_IDLE: if (rx_prev && !rx_sync) rx_state <= RX_START;
                RX_START: if (rx_half) begin
                    rx_bit_idx <= '0;
                    rx_state   <= rx_sync ? RX_IDLE : RX_DATA;
                end
                RX_DATA: if (rx_full) begin
                    rx_shift <= {rx_sync, rx_shift[7:1]};
                    if (rx_bit_idx == 3'd7) rx_state <= RX_STOP;
                    else rx_bit_idx <= rx_bit_idx + 3'd1;
                end
                RX_STOP: if (rx_full) rx_state <= RX_IDLE;
                default: rx_state <= RX_IDLE;
            endcase
        end
    end

    // Set conditions are tested first so a flag raised during its own clear survives.
    always_ff @(posedge clk) begin
        if (reset) begin
            tx_done   <= 1'b0;
            rx_ready  <= 1'b0;
            frame_err <= 1'b0;
            overrun   <= 1'b0;
            rx_data   <= '0;
            tx_irq_en <= 1'b0;
            rx_irq_en <= 1'b0;
            irqout    <= 1'b0;
        end else begin
            if (wr_con) {rx_irq_en, tx_irq_en} <= Write_data[1:0];
            if (tx_done_set) tx_done <= 1'b1;
            else if (rd_con) tx_done <= 1'b0;
            if (rx_ok) rx_data <= rx_shift;
            if (rx_ok) rx_ready <= 1'b1;
            else if (rd_rxd) rx_ready <= 1'b0;
            if (rx_ok && rx_ready && !rd_rxd) overrun <= 1'b1;
            else if (rd_con) overrun <= 1'b0;
            if (rx_bad) frame_err <= 1'b1;
            else if (rd_con) frame_err <= 1'b0;
            irqout <= (tx_irq_en && tx_done) || (rx_irq_en && rx_ready);
        end
    end

    always_comb begin
        Read_data = '0;
        if (MemRead) begin
            if (sel_txd)      Read_data = {24'b0, tx_byte};
            else if (sel_rxd) Read_data = {24'b0, rx_data};
            else if (sel_con) Read_data = {25'b0, overrun, frame_err, tx_busy,
                                           rx_ready, tx_done, rx_irq_en, tx_irq_en};
        end
    end

endmodule

// File: tb/tb_uart_bus_slave.sv
// Directed bench for uart_bus_slave at 16 clocks per bit: TX framing, RX
// receive, glitch rejection, framing error, overrun, decode and reset abort.
module tb_uart_bus_slave;
    import uart_pkg::*;

    localparam int          CPB  = 16;
    localparam logic [31:0] BASE = 32'h40000018;
    localparam logic [31:0] TXD  = BASE;
    localparam logic [31:0] RXD  = BASE + 32'd4;
    localparam logic [31:0] CON  = BASE + 32'd8;

    logic        clk = 1'b0;
    logic        reset, MemRead, MemWrite, uart_rx;
    logic [31:0] Address, Write_data;
    logic [31:0] Read_data;
    logic        uart_tx, irqout;

    int checks = 0;
    int errors = 0;

    uart_bus_slave #(.CLKS_PER_BIT(CPB), .BASE_ADDR(BASE)) dut (
        .clk(clk), .reset(reset), .MemRead(MemRead), .MemWrite(MemWrite),
        .Address(Address), .Write_data(Write_data), .Read_data(Read_data),
        .uart_rx(uart_rx), .uart_tx(uart_tx), .irqout(irqout)
    );

    always #5 clk = ~clk;

    // Combinational look at CON inside the low clock phase: no edge sees MemRead.
    task automatic peek_con(output logic [31:0] v);
        MemRead = 1'b1;
        Address = CON;
        #1;
        v = Read_data;
        MemRead = 1'b0;
    endtask

    task automatic cpu_read(input logic [31:0] a, output logic [31:0] d);
        @(negedge clk);
        MemRead = 1'b1;
        Address = a;
        #1;
        d = Read_data;
        @(negedge clk);
        MemRead = 1'b0;
    endtask

    task automatic cpu_write(input logic [31:0] a, input logic [31:0] d);
        @(negedge clk);
        MemWrite   = 1'b1;
        Address    = a;
        Write_data = d;
        @(negedge clk);
        MemWrite = 1'b0;
    endtask

    // Called right after the write edge; optionally attempts a TXD write of 0x55 at drop_k.
    task automatic check_tx_frame(input logic [7:0] b, input int drop_k);
        logic [9:0]  fr;
        logic [31:0] v;
        fr = {1'b1, b, 1'b0};
        for (int k = 0; k < 10 * CPB; k++) begin
            MemWrite = 1'b0;
            checks++;
            if (uart_tx !== fr[k / CPB]) begin
                errors++;
                $display("FAIL tx_bit k=%0d got %b want %b", k, uart_tx, fr[k / CPB]);
            end
            peek_con(v);
            checks++;
            if (v[CON_TX_BUSY] !== 1'b1) begin
                errors++;
                $display("FAIL tx_busy k=%0d got %b want 1", k, v[CON_TX_BUSY]);
            end
            if (k == drop_k) begin
                MemWrite   = 1'b1;
                Address    = TXD;
                Write_data = 32'h55;
            end
            @(negedge clk);
        end
        MemWrite = 1'b0;
        peek_con(v);
        checks++;
        if (uart_tx !== 1'b1 || v[CON_TX_BUSY] !== 1'b0 || v[CON_TX_DONE] !== 1'b1) begin
            errors++;
            $display("FAIL tx_end got tx=%b busy=%b done=%b want 1 0 1",
                     uart_tx, v[CON_TX_BUSY], v[CON_TX_DONE]);
        end
    endtask

    // Drives start, data, stop and one idle bit; records rx_ready rise and irqout around it.
    task automatic send_rx(input logic [7:0] b, input logic stop_bit,
                           output logic rose, output logic irq_at_rise, output logic irq_after);
        logic [9:0]  fr;
        logic [31:0] v;
        logic        prev, pending;
        fr = {stop_bit, b, 1'b0};
        rose = 1'b0; irq_at_rise = 1'bx; irq_after = 1'bx; pending = 1'b0;
        peek_con(v);
        prev = v[CON_RX_READY];
        for (int k = 0; k < 11 * CPB; k++) begin
            @(negedge clk);
            if (pending) begin
                irq_after = irqout;
                pending = 1'b0;
            end
            uart_rx = (k < 10 * CPB) ? fr[k / CPB] : 1'b1;
            peek_con(v);
            if (!rose && v[CON_RX_READY] && !prev) begin
                rose = 1'b1;
                irq_at_rise = irqout;
                pending = 1'b1;
            end
            prev = v[CON_RX_READY];
        end
    endtask

    task automatic test_reset();
        logic [31:0] d;
        checks++;
        if (uart_tx !== 1'b1 || irqout !== 1'b0) begin
            errors++;
            $display("FAIL reset_pins got tx=%b irq=%b want 1 0", uart_tx, irqout);
        end
        peek_con(d);
        checks++;
        if (d !== 32'h0) begin errors++; $display("FAIL reset_con got %h want 0", d); end
        cpu_read(RXD, d);
        checks++;
        if (d !== 32'h0) begin errors++; $display("FAIL reset_rxd got %h want 0", d); end
        cpu_read(TXD, d);
        checks++;
        if (d !== 32'h0) begin errors++; $display("FAIL reset_txd got %h want 0", d); end
        checks++;
        if (dut.rx_state !== RX_IDLE || dut.tx_state !== TX_IDLE) begin
            errors++;
            $display("FAIL reset_fsm got rx=%0d tx=%0d want 0 0", dut.rx_state, dut.tx_state);
        end
    endtask

    task automatic test_decode();
        logic [31:0] d;
        cpu_write(CON, 32'hFFFF_FFFF);
        cpu_read(CON, d);
        checks++;
        if (d !== 32'h3) begin errors++; $display("FAIL con_mask got %h want 3", d); end
        cpu_read(BASE + 32'd12, d);
        checks++;
        if (d !== 32'h0) begin errors++; $display("FAIL unmapped got %h want 0", d); end
        @(negedge clk);
        Address = CON;
        #1;
        checks++;
        if (Read_data !== 32'h0) begin errors++; $display("FAIL no_read got %h want 0", Read_data); end
        cpu_write(CON, 32'h0);
    endtask

    task automatic test_tx();
        logic [31:0] d;
        cpu_write(CON, 32'h1);
        cpu_write(TXD, 32'hA5);
        check_tx_frame(8'hA5, -1);
        checks++;
        if (irqout !== 1'b0) begin errors++; $display("FAIL tx_irq_early got %b want 0", irqout); end
        @(negedge clk);
        checks++;
        if (irqout !== 1'b1) begin errors++; $display("FAIL tx_irq got %b want 1", irqout); end
        cpu_read(CON, d);
        checks++;
        if (d !== 32'h5) begin errors++; $display("FAIL con_first got %h want 5", d); end
        cpu_read(CON, d);
        checks++;
        if (d !== 32'h1) begin errors++; $display("FAIL con_second got %h want 1", d); end
        @(negedge clk);
        checks++;
        if (irqout !== 1'b0) begin errors++; $display("FAIL tx_irq_clear got %b want 0", irqout); end
        cpu_write(CON, 32'h0);
    endtask

    task automatic test_tx_drop();
        logic [31:0] d;
        cpu_write(TXD, 32'hA5);
        check_tx_frame(8'hA5, 40);
        cpu_read(TXD, d);
        checks++;
        if (d !== 32'hA5) begin errors++; $display("FAIL txd_keep got %h want a5", d); end
        cpu_read(CON, d);
    endtask

    task automatic test_rx_good();
        logic [31:0] d;
        logic rose, ia, ib;
        cpu_write(CON, 32'h2);
        send_rx(8'h3C, 1'b1, rose, ia, ib);
        checks++;
        if (rose !== 1'b1 || ia !== 1'b0 || ib !== 1'b1) begin
            errors++;
            $display("FAIL rx_ready_irq got rose=%b irq=%b,%b want 1 0,1", rose, ia, ib);
        end
        cpu_read(RXD, d);
        checks++;
        if (d !== 32'h3C) begin errors++; $display("FAIL rxd_3c got %h want 3c", d); end
        peek_con(d);
        checks++;
        if (d[CON_RX_READY] !== 1'b0 || irqout !== 1'b1) begin
            errors++;
            $display("FAIL rx_clear got rdy=%b irq=%b want 0 1", d[CON_RX_READY], irqout);
        end
        @(negedge clk);
        checks++;
        if (irqout !== 1'b0) begin errors++; $display("FAIL rx_irq_fall got %b want 0", irqout); end
    endtask

    task automatic test_rx_glitch();
        logic [31:0] d;
        @(negedge clk);
        uart_rx = 1'b0;
        repeat (4) @(negedge clk);
        uart_rx = 1'b1;
        repeat (40) @(negedge clk);
        peek_con(d);
        checks++;
        if (d !== 32'h2 || dut.rx_state !== RX_IDLE) begin
            errors++;
            $display("FAIL glitch got con=%h state=%0d want 2 0", d, dut.rx_state);
        end
    endtask

    task automatic test_rx_frame_err();
        logic [31:0] d;
        logic rose, ia, ib;
        send_rx(8'h99, 1'b0, rose, ia, ib);
        checks++;
        if (rose !== 1'b0 || irqout !== 1'b0) begin
            errors++;
            $display("FAIL ferr_ready got rose=%b irq=%b want 0 0", rose, irqout);
        end
        cpu_read(CON, d);
        checks++;
        if (d !== 32'h22) begin errors++; $display("FAIL ferr_con got %h want 22", d); end
        cpu_read(RXD, d);
        checks++;
        if (d !== 32'h3C) begin errors++; $display("FAIL ferr_rxd got %h want 3c", d); end
        cpu_read(CON, d);
        checks++;
        if (d !== 32'h2) begin errors++; $display("FAIL ferr_clear got %h want 2", d); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] d;
        logic rose, ia, ib;
        send_rx(8'h11, 1'b1, rose, ia, ib);
        send_rx(8'h22, 1'b1, rose, ia, ib);
        cpu_read(CON, d);
        checks++;
        if (d !== 32'h4A) begin errors++; $display("FAIL ovr_con got %h want 4a", d); end
        cpu_read(RXD, d);
        checks++;
        if (d !== 32'h22) begin errors++; $display("FAIL ovr_rxd got %h want 22", d); end
        cpu_read(CON, d);
        checks++;
        if (d !== 32'h2) begin errors++; $display("FAIL ovr_clear got %h want 2", d); end
        cpu_write(CON, 32'h0);
    endtask

    task automatic test_reset_abort();
        logic [31:0] d;
        cpu_write(TXD, 32'hA5);
        repeat (70) @(negedge clk);
        checks++;
        if (uart_tx !== 1'b0) begin errors++; $display("FAIL abort_bit3 got %b want 0", uart_tx); end
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        peek_con(d);
        checks++;
        if (uart_tx !== 1'b1 || d !== 32'h0) begin
            errors++;
            $display("FAIL abort got tx=%b con=%h want 1 0", uart_tx, d);
        end
        cpu_write(TXD, 32'h3C);
        check_tx_frame(8'h3C, -1);
    endtask

    initial begin
        reset = 1'b1; MemRead = 1'b0; MemWrite = 1'b0;
        Address = '0; Write_data = '0; uart_rx = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        test_reset();
        test_decode();
        test_tx();
        test_tx_drop();
        test_rx_good();
        test_rx_glitch();
        test_rx_frame_err();
        test_back_to_back();
        test_reset_abort();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
